syscall_console: RTL and testbench
==================================

SYSCALL_CONSOLE -- requirements
Module: syscall_console

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, meaning the maximum characters emitted for one print_string before abort.
REQ-002 SHALL have parameter BIG_ENDIAN, default 1, meaning 1 selects byte lane 0 = mem_rd_data[31:24] and 0 selects byte lane 0 = [7:0].
REQ-003 SHALL have port clk  input  1  clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sys_req  input  1  syscall request from the ID stage, sampled only in IDLE.
REQ-006 SHALL have port sys_v0  input  32  service code.
REQ-007 SHALL have port sys_a0  input  32  argument: string byte address, character, or value.
REQ-008 SHALL have port busy  output  1  high while a request is in service, used for the CPU stall.
REQ-009 SHALL have port mem_rd_en  output  1  data memory word read strobe.
REQ-010 SHALL have port mem_addr  output  32  word-aligned read address, bits [1:0] always 0.
REQ-011 SHALL have port mem_rd_data  input  32  read word, valid exactly one cycle after mem_rd_en.
REQ-012 SHALL have port char_valid  output  1  output character valid.
REQ-013 SHALL have port char_data  output  8  output character.
REQ-014 SHALL have port char_ready  input  1  sink accepts the character.
REQ-015 SHALL have port exit_req  output  1  program exit, sticky.
REQ-016 SHALL have port err  output  1  one-cycle pulse on an unsupported code or MAX_LEN overrun.
REQ-017 SHALL have port chars_out  output  32  running count of accepted characters.

Function
REQ-018 SHALL use the states IDLE, FETCH, WAIT, EMIT, HEX and HALT.
REQ-019 SHALL, in IDLE with sys_req=1, capture sys_v0 and sys_a0 and dispatch as follows: 4 -> FETCH; 11 -> EMIT with char_data=a0[7:0]; 34 -> HEX; 10 -> HALT; any other code -> err pulse and remain IDLE.
REQ-020 SHALL drive busy high exactly when state is not IDLE and not HALT.
REQ-021 SHALL ignore sys_req in every state other than IDLE, with no queuing.
REQ-022 SHALL, in FETCH, assert mem_rd_en for one cycle with mem_addr = ptr & ~3, then go to WAIT.
REQ-023 SHALL, in WAIT, latch mem_rd_data into a word buffer and select byte lane ptr[1:0] per BIG_ENDIAN.
REQ-024 SHALL, on a NUL byte in WAIT or EMIT selection, return to IDLE without emitting it.
REQ-025 SHALL otherwise present the selected byte in EMIT.
REQ-026 SHALL hold char_valid high and char_data stable in EMIT until the cycle char_valid&char_ready=1.
REQ-027 SHALL count a character as transferred only in a cycle with char_valid&char_ready=1.
REQ-028 SHALL, after each transfer in string mode, increment ptr by 1 and the length count by 1.
REQ-029 SHALL, after a string-mode transfer, read the next byte from the word buffer (no new fetch) while ptr[1:0]!=0, and go to FETCH when ptr wraps to lane 0.
REQ-030 SHALL allow ptr to wrap modulo 2^32.
REQ-031 SHALL, when the length count reaches MAX_LEN with no NUL found, pulse err and return to IDLE.
REQ-032 SHALL, in HEX, emit the 8 digits of a0 most-significant nibble first, using ASCII '0'-'9' and 'A'-'F', with no prefix, each digit through the same handshake, then return to IDLE.
REQ-033 SHALL, for code 11, return to IDLE after one transfer.
REQ-034 SHALL increment chars_out by 1 per transfer, wrapping at 2^32.
REQ-035 SHALL, in HALT, set exit_req=1 permanently, hold busy=0, and ignore all requests until reset.
REQ-036 SHALL keep char_valid=0 in every state except EMIT and HEX.
REQ-037 SHALL keep mem_rd_en=0 in every state except FETCH.

Reset
REQ-038 SHALL, on rst_n=0 at any time including mid-string or mid-handshake, immediately force state=IDLE, busy=0, char_valid=0, char_data=0, mem_rd_en=0, mem_addr=0, exit_req=0, err=0, chars_out=0, ptr=0 and the length count=0.
REQ-039 SHALL drop any partially emitted string on reset and emit nothing further from it after release.

Verification
REQ-040 SHALL be verified by: v0=4, a0=0x102, memory word 0x100=0x0000_4869, word 0x104=0x2100_0000, BIG_ENDIAN=1, char_ready=1 -> 'H','i','!' emitted, exactly 2 reads, chars_out=3, then IDLE.
REQ-041 SHALL be verified by: v0=34, a0=0xDEAD00F1, char_ready toggling 1/0 -> "DEAD00F1" in order, char_data stable while char_ready=0, busy high throughout.
REQ-042 SHALL be verified by: v0=11, a0=0x41, char_ready held 0 for 5 cycles -> char_valid high for 6 cycles with 0x41, then one transfer, chars_out=1.
REQ-043 SHALL be verified by: v0=7 -> one-cycle err pulse, no char_valid, no mem_rd_en, busy stays 0.
REQ-044 SHALL be verified by: MAX_LEN=4, a string with no NUL -> 4 characters emitted, err pulse, then IDLE.
REQ-045 SHALL be verified by: v0=10, then a v0=4 request, then rst_n low mid-string -> exit_req=1 and the v0=4 request ignored; after the reset all outputs are 0, and a fresh request is serviced normally.

Source files
------------

// File: rtl/syscall_console.sv
// syscall_console: services print_string / print_char / print_hex / exit syscalls,
// streaming characters through a valid/ready sink and reading strings a word at a time.
module syscall_console #(
    parameter int MAX_LEN    = 256,
    parameter bit BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys_req,
    input  logic [31:0] sys_v0,
    input  logic [31:0] sys_a0,
    output logic        busy,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        exit_req,
    output logic        err,
    output logic [31:0] chars_out
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, HEX, HALT} state_t;

    state_t      state;
    logic [31:0] ptr, word_buf, len, hex_sr;
    logic [2:0]  nib;
    logic        str_mode;
    logic [31:0] ptr_nx;
    logic [7:0]  rd_byte, buf_byte;

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
        return 8'(w >> {(BIG_ENDIAN ? ~i : i), 3'b000});
    endfunction

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign ptr_nx   = ptr + 32'd1;
    assign rd_byte  = lane(mem_rd_data, ptr[1:0]);
    assign buf_byte = lane(word_buf, ptr_nx[1:0]);
    assign busy     = (state != IDLE) && (state != HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            word_buf   <= '0;
            len        <= '0;
            hex_sr     <= '0;
            nib        <= '0;
            str_mode   <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            char_valid <= 1'b0;
            char_data  <= '0;
            exit_req   <= 1'b0;
            err        <= 1'b0;
            chars_out  <= '0;
        end else begin
            err       <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: if (sys_req) begin
                    if (sys_v0 == 32'd4) begin
                        ptr       <= sys_a0;
                        len       <= '0;
                        str_mode  <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= {sys_a0[31:2], 2'b00};
                        state     <= FETCH;
                    end else if (sys_v0 == 32'd11) begin
                        str_mode   <= 1'b0;
                        char_valid <= 1'b1;
                        char_data  <= sys_a0[7:0];
                        state      <= EMIT;
                    end else if (sys_v0 == 32'd34) begin
                        hex_sr     <= {sys_a0[27:0], 4'h0};
                        nib        <= '0;
                        char_valid <= 1'b1;
                        char_data  <= hex(sys_a0[31:28]);
                        state      <= HEX;
                    end else if (sys_v0 == 32'd10) begin
                        exit_req <= 1'b1;
                        state    <= HALT;
                    end else begin
                        err <= 1'b1;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    word_buf <= mem_rd_data;
                    if (rd_byte == 8'h00) begin
                        state <= IDLE;
                    end else begin
                        char_valid <= 1'b1;
                        char_data  <= rd_byte;
                        state      <= EMIT;
                    end
                end
                EMIT: if (char_valid && char_ready) begin
                    chars_out  <= chars_out + 32'd1;
                    char_valid <= 1'b0;
                    if (!str_mode) begin
                        state <= IDLE;
                    end else begin
                        ptr <= ptr_nx;
                        len <= len + 32'd1;
                        // Length limit takes priority over continuing the string
                        if (len + 32'd1 == 32'(MAX_LEN)) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else if (ptr_nx[1:0] == 2'b00) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {ptr_nx[31:2], 2'b00};
                            state     <= FETCH;
                        end else if (buf_byte == 8'h00) begin
                            state <= IDLE;
                        end else begin
                            char_valid <= 1'b1;
                            char_data  <= buf_byte;
                        end
                    end
                end
                HEX: if (char_valid && char_ready) begin
                    chars_out <= chars_out + 32'd1;
                    if (nib == 3'd7) begin
                        char_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        nib       <= nib + 3'd1;
                        char_data <= hex(hex_sr[31:28]);
                        hex_sr    <= hex_sr << 4;
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_console.sv
// tb_syscall_console: directed syscall scenarios; expected characters go into a
// scoreboard queue that a negedge monitor drains on every accepted transfer.
module tb_syscall_console;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sys_req = 1'b0;
    logic [31:0] sys_v0 = '0, sys_a0 = '0;
    logic        busy, mem_rd_en, char_valid, exit_req, err;
    logic [31:0] mem_addr, chars_out;
    logic [31:0] mem_rd_data = '0;
    logic [7:0]  char_data;
    logic        char_ready = 1'b1;
    logic        tgl = 1'b0;

    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_rd = 0, n_err = 0, n_busy = 0;
    logic [7:0] exp_q[$];
    logic       pend = 1'b0;
    logic [7:0] pend_data = '0;

    syscall_console #(.MAX_LEN(4), .BIG_ENDIAN(1)) dut (
        .clk(clk), .rst_n(rst_n), .sys_req(sys_req), .sys_v0(sys_v0), .sys_a0(sys_a0),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .exit_req(exit_req), .err(err), .chars_out(chars_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0000_4869;
            32'h104: return 32'h2100_0000;
            32'h200: return 32'h4142_4344;
            32'h204: return 32'h4546_4748;
            default: return 32'h5555_5555;
        endcase
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= rd_word(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (tgl) char_ready = ~char_ready;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_valid", {31'd0, char_valid}, 32'd1);
                chk("hold_data", {24'd0, char_data}, {24'd0, pend_data});
            end
            if (char_valid) begin
                n_valid++;
                chk("busy_while_valid", {31'd0, busy}, 32'd1);
            end
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_char: got %h expected none", char_data);
                end else begin
                    chk("char", {24'd0, char_data}, {24'd0, exp_q.pop_front()});
                end
            end
            pend = char_valid && !char_ready;
            pend_data = char_data;
            if (mem_rd_en) begin
                n_rd++;
                chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            end
            if (err) n_err++;
            if (busy) n_busy++;
        end
    end

    task automatic clr();
        n_valid = 0; n_rd = 0; n_err = 0; n_busy = 0;
    endtask

    task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
        @(posedge clk);
        #1;
        sys_req = 1'b1; sys_v0 = v0; sys_a0 = a0;
        @(posedge clk);
        #1;
        sys_req = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got busy expected idle");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_flags", {27'd0, busy, char_valid, mem_rd_en, exit_req, err}, 32'd0);
        chk("rst_char_data", {24'd0, char_data}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_chars_out", chars_out, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // "Hi!" across two words, big-endian lanes
        clr(); push_str("Hi!");
        issue(32'd4, 32'h102);
        wait_idle();
        chk("hi_reads", n_rd, 32'd2);
        chk("hi_chars_out", chars_out, 32'd3);
        chk("hi_err", n_err, 32'd0);

        // hex print with stalling sink
        clr(); push_str("DEAD00F1"); tgl = 1'b1;
        issue(32'd34, 32'hDEAD_00F1);
        wait_idle();
        tgl = 1'b0;
        @(posedge clk);
        #1 char_ready = 1'b1;
        chk("hex_chars_out", chars_out, 32'd11);
        chk("hex_reads", n_rd, 32'd0);

        // single char held off for five cycles
        clr(); push_str("A");
        @(posedge clk);
        #1 char_ready = 1'b0;
        issue(32'd11, 32'h41);
        repeat (5) @(posedge clk);
        #1 char_ready = 1'b1;
        wait_idle();
        chk("char_valid_cycles", n_valid, 32'd6);
        chk("char_chars_out", chars_out, 32'd12);

        // unsupported code
        clr();
        issue(32'd7, 32'h0);
        repeat (3) @(negedge clk);
        chk("bad_err_pulses", n_err, 32'd1);
        chk("bad_valid", n_valid, 32'd0);
        chk("bad_reads", n_rd, 32'd0);
        chk("bad_busy", n_busy, 32'd0);

        // no NUL within MAX_LEN=4
        clr(); push_str("BCDE");
        issue(32'd4, 32'h201);
        wait_idle();
        chk("max_reads", n_rd, 32'd2);
        chk("max_err_pulses", n_err, 32'd1);
        chk("max_chars_out", chars_out, 32'd16);

        // exit, then an ignored request
        clr();
        issue(32'd10, 32'h0);
        repeat (2) @(negedge clk);
        chk("halt_exit", {31'd0, exit_req}, 32'd1);
        issue(32'd4, 32'h100);
        repeat (10) @(negedge clk);
        chk("halt_ignored_reads", n_rd, 32'd0);
        chk("halt_ignored_valid", n_valid, 32'd0);
        chk("halt_busy", n_busy, 32'd0);
        chk("halt_sticky", {31'd0, exit_req}, 32'd1);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of a stalled string
        clr();
        char_ready = 1'b0;
        issue(32'd4, 32'h201);
        repeat (6) @(posedge clk);
        chk("mid_valid_before_rst", {31'd0, char_valid}, 32'd1);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1; char_ready = 1'b1;
        clr();
        repeat (10) @(negedge clk);
        chk("after_rst_valid", n_valid, 32'd0);
        chk("after_rst_reads", n_rd, 32'd0);

        push_str("Z");
        issue(32'd11, 32'h5A);
        wait_idle();
        chk("fresh_chars_out", chars_out, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
